// File: rtl/ct_f_spsram_param.sv
// Single-port SRAM with byte-lane write mask, optional output register and a
// post-reset zero-fill sweep that blocks accesses until the array is cleared.
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_BUSY,
  output logic                  dbg_state_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_vld_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_dout;
  logic [LANES-1:0]        lane_en;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    unused_wen;

  // Only the top bit of each lane's WEN field selects that lane.
  always_comb begin
    lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = ~WEN[(k+1)*LANE_WIDTH-1];
    end
  end
  assign unused_wen = ^WEN;

  // Handshake: a request is taken on the rising edge where CEN=0, reset is
  // released and the sweep is finished; anything else is dropped, never queued.
  assign accept = cpurst_b & ~CEN & (state_q == ST_READY);
  assign wr_acc = accept & ~GWEN & (|lane_en);
  assign rd_acc = accept & GWEN;

  always_ff @(posedge CLK) begin
    if (!cpurst_b) begin
      state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    INIT_BUSY = 1'b0;
    case (state_q)
      ST_INIT: begin
        INIT_BUSY = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign dbg_state_o = state_q;

  // Array is deliberately not reset; the sweep provides known contents.
  always_ff @(posedge CLK) begin
    if (cpurst_b && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) mem_q[A][k*LANE_WIDTH +: LANE_WIDTH] <= D[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!cpurst_b) begin
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (accept) addr_q <= A;
      rd_vld_q <= rd_acc;
    end
  end

  assign rd_dout = mem_q[addr_q];

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q_q;
    logic                  vld2_q;
    always_ff @(posedge CLK) begin
      if (!cpurst_b) begin
        q_q    <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= rd_vld_q;
        if (rd_vld_q) q_q <= rd_dout;
      end
    end
    assign Q     = q_q;
    assign Q_VLD = vld2_q;
  end else begin : g_noreg
    logic [DATA_WIDTH-1:0] hold_q;
    always_ff @(posedge CLK) begin
      if (!cpurst_b) begin
        hold_q <= '0;
      end else if (rd_vld_q) begin
        hold_q <= rd_dout;
      end
    end
    assign Q     = rd_vld_q ? rd_dout : hold_q;
    assign Q_VLD = rd_vld_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: default config (OUT_REG=0, with sweep) and a
// 64-bit/16-bit-lane config with OUT_REG=1 and no sweep.
module tb_ct_f_spsram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: defaults ----------------
  logic        rst_a_n, cen_a, gwen_a, vld_a, busy_a, dbg_a;
  logic [10:0] a_a;
  logic [31:0] wen_a, d_a, q_a;

  ct_f_spsram_param u_dut_a (
    .CLK(clk), .cpurst_b(rst_a_n), .A(a_a), .CEN(cen_a), .GWEN(gwen_a),
    .WEN(wen_a), .D(d_a), .Q(q_a), .Q_VLD(vld_a), .INIT_BUSY(busy_a),
    .dbg_state_o(dbg_a)
  );

  // ---------------- DUT B: small, wide, registered ----------------
  logic        rst_b_n, cen_b, gwen_b, vld_b, busy_b, dbg_b;
  logic [5:0]  a_b;
  logic [63:0] wen_b, d_b, q_b;

  ct_f_spsram_param #(
    .ADDR_WIDTH(6), .DATA_WIDTH(64), .LANE_WIDTH(16), .OUT_REG(1), .INIT_EN(0)
  ) u_dut_b (
    .CLK(clk), .cpurst_b(rst_b_n), .A(a_b), .CEN(cen_b), .GWEN(gwen_b),
    .WEN(wen_b), .D(d_b), .Q(q_b), .Q_VLD(vld_b), .INIT_BUSY(busy_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- reference models and scoreboards ----------------
  logic [31:0] model_a [2048];
  logic [63:0] model_b [64];
  logic [31:0] exp_q_a[$];
  int          exp_cyc_a[$];
  logic [63:0] exp_q_b[$];
  int          exp_cyc_b[$];
  logic [31:0] last_q_a;
  logic [63:0] last_q_b;
  int          init_left_a = 2048;
  bit          mon_en_a = 1'b0;
  bit          mon_en_b = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic acc_a(input logic cen, input logic gwen, input logic [10:0] a,
                       input logic [31:0] wen, input logic [31:0] d);
    logic take;
    cen_a = cen; gwen_a = gwen; a_a = a; wen_a = wen; d_a = d;
    take = !cen && rst_a_n && (init_left_a == 0);
    @(posedge clk);
    if (rst_a_n && init_left_a > 0) init_left_a--;
    #1;
    if (take) begin
      if (!gwen) begin
        for (int k = 0; k < 4; k++)
          if (!wen[k*8+7]) model_a[a][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        exp_q_a.push_back(model_a[a]);
        exp_cyc_a.push_back(cyc);
      end
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) acc_a(1'b1, 1'b1, 11'h0, '1, 32'h0);
  endtask

  task automatic reset_a(input int n);
    rst_a_n = 1'b0; cen_a = 1'b1;
    exp_q_a.delete(); exp_cyc_a.delete();
    repeat (n) begin
      @(posedge clk);
      last_q_a = '0;
      init_left_a = 2048;
    end
    #1;
    rst_a_n = 1'b1;
    mon_en_a = 1'b1;
  endtask

  task automatic acc_b(input logic cen, input logic gwen, input logic [5:0] a,
                       input logic [63:0] wen, input logic [63:0] d);
    logic take;
    cen_b = cen; gwen_b = gwen; a_b = a; wen_b = wen; d_b = d;
    take = !cen && rst_b_n;
    @(posedge clk);
    #1;
    if (take) begin
      if (!gwen) begin
        for (int k = 0; k < 4; k++)
          if (!wen[k*16+15]) model_b[a][k*16 +: 16] = d[k*16 +: 16];
      end else begin
        exp_q_b.push_back(model_b[a]);
        exp_cyc_b.push_back(cyc + 1);
      end
    end
  endtask

  task automatic idle_b(input int n);
    repeat (n) acc_b(1'b1, 1'b1, 6'h0, '1, 64'h0);
  endtask

  task automatic reset_b(input int n);
    rst_b_n = 1'b0; cen_b = 1'b1;
    exp_q_b.delete(); exp_cyc_b.delete();
    repeat (n) begin
      @(posedge clk);
      last_q_b = '0;
    end
    #1;
    rst_b_n = 1'b1;
    mon_en_b = 1'b1;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en_a) begin
      checks++;
      if (busy_a !== (init_left_a > 0)) begin
        errors++;
        $display("FAIL busy_a cyc=%0d got %b want %b", cyc, busy_a, (init_left_a > 0));
      end
      checks++;
      if (vld_a === 1'b1) begin
        if (exp_q_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld_a cyc=%0d q=%h want no valid", cyc, q_a);
        end else begin
          logic [31:0] e;
          int c;
          e = exp_q_a.pop_front();
          c = exp_cyc_a.pop_front();
          if (q_a !== e || cyc != c) begin
            errors++;
            $display("FAIL read_a q=%h cyc=%0d want q=%h cyc=%0d", q_a, cyc, e, c);
          end
          last_q_a = e;
        end
      end else if (vld_a !== 1'b0 || q_a !== last_q_a) begin
        errors++;
        $display("FAIL hold_a cyc=%0d vld=%b q=%h want vld=0 q=%h", cyc, vld_a, q_a, last_q_a);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en_b) begin
      checks++;
      if (busy_b !== 1'b0) begin
        errors++;
        $display("FAIL busy_b cyc=%0d got %b want 0", cyc, busy_b);
      end
      checks++;
      if (vld_b === 1'b1) begin
        if (exp_q_b.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld_b cyc=%0d q=%h want no valid", cyc, q_b);
        end else begin
          logic [63:0] e;
          int c;
          e = exp_q_b.pop_front();
          c = exp_cyc_b.pop_front();
          if (q_b !== e || cyc != c) begin
            errors++;
            $display("FAIL read_b q=%h cyc=%0d want q=%h cyc=%0d", q_b, cyc, e, c);
          end
          last_q_b = e;
        end
      end else if (vld_b !== 1'b0 || q_b !== last_q_b) begin
        errors++;
        $display("FAIL hold_b cyc=%0d vld=%b q=%h want vld=0 q=%h", cyc, vld_b, q_b, last_q_b);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a_n = 1'b0; cen_a = 1'b1; gwen_a = 1'b1; a_a = '0; wen_a = '1; d_a = '0;
    rst_b_n = 1'b0; cen_b = 1'b1; gwen_b = 1'b1; a_b = '0; wen_b = '1; d_b = '0;
    last_q_a = '0; last_q_b = '0;
    for (int i = 0; i < 2048; i++) model_a[i] = '0;
    for (int i = 0; i < 64; i++) model_b[i] = '0;

    // Sweep, restart mid-sweep, and a read dropped while busy.
    reset_a(3);
    idle_a(999);
    acc_a(1'b0, 1'b1, 11'h123, '1, 32'h0);
    reset_a(2);
    idle_a(2048);

    acc_a(1'b0, 1'b1, 11'h5A3, '1, 32'h0);
    idle_a(2);

    // Lane-1-only write over known contents.
    acc_a(1'b0, 1'b0, 11'h010, 32'h0, 32'h11223344);
    acc_a(1'b0, 1'b0, 11'h010, 32'hFFFF00FF, 32'hAABBCCDD);
    acc_a(1'b0, 1'b1, 11'h010, '1, 32'h0);
    idle_a(2);

    // All lanes disabled: no write and no read response.
    acc_a(1'b0, 1'b0, 11'h010, 32'hFFFFFFFF, 32'h55555555);
    idle_a(2);
    acc_a(1'b0, 1'b1, 11'h010, '1, 32'h0);

    // Top address write followed immediately by a read, then idle hold.
    acc_a(1'b0, 1'b0, 11'h7FF, 32'h0, 32'hDEADBEEF);
    acc_a(1'b0, 1'b1, 11'h7FF, '1, 32'h0);
    idle_a(5);

    repeat (300) begin
      logic [31:0] wen;
      wen = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom();
      acc_a(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 11'($urandom_range(0, 15)),
            wen, $urandom());
    end
    idle_a(4);

    // Second configuration: no sweep, contents defined by writes.
    reset_b(3);
    for (int i = 0; i < 64; i++) acc_b(1'b0, 1'b0, 6'(i), 64'h0, {$urandom(), $urandom()});
    acc_b(1'b0, 1'b1, 6'h01, '1, 64'h0);
    acc_b(1'b0, 1'b1, 6'h02, '1, 64'h0);
    acc_b(1'b0, 1'b1, 6'h03, '1, 64'h0);
    idle_b(4);

    // Read caught in the output pipeline by reset must vanish.
    acc_b(1'b0, 1'b1, 6'h05, '1, 64'h0);
    reset_b(2);
    idle_b(3);

    repeat (1000) begin
      logic [63:0] wen;
      wen = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom(), $urandom()};
      acc_b(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 6'($urandom_range(0, 63)),
            wen, {$urandom(), $urandom()});
    end
    idle_b(5);

    checks++;
    if (exp_q_a.size() != 0) begin
      errors++;
      $display("FAIL drain_a pending=%0d want 0", exp_q_a.size());
    end
    checks++;
    if (exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_b pending=%0d want 0", exp_q_b.size());
    end

    mon_en_a = 1'b0;
    mon_en_b = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_param.md
CT_F_SPSRAM_PARAM -- requirements
Module: ct_f_spsram_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word-address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; must be an integer multiple of LANE_WIDTH.
REQ-003 SHALL have parameter LANE_WIDTH, default 8, byte-lane width; LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 SHALL have parameter OUT_REG, default 0, 1 adds one output pipeline stage.
REQ-005 SHALL have parameter INIT_EN, default 1, 1 enables the post-reset zero-fill sweep.
REQ-006 CLK  input  1  single clock; all state updates on its rising edge.
REQ-007 cpurst_b  input  1  reset, synchronous, active-low.
REQ-008 A  input  ADDR_WIDTH  word address.
REQ-009 CEN  input  1  chip enable, active-low.
REQ-010 GWEN  input  1  global write enable, active-low; 1 = read.
REQ-011 WEN  input  DATA_WIDTH  bit write-enable mask, active-low; lane k enabled when WEN[(k+1)*LANE_WIDTH-1] = 0.
REQ-012 D  input  DATA_WIDTH  write data.
REQ-013 Q  output  DATA_WIDTH  read data, held between reads.
REQ-014 Q_VLD  output  1  one-cycle pulse marking new read data on Q.
REQ-015 INIT_BUSY  output  1  1 while the zero-fill sweep runs; accesses are ignored.

Function
REQ-016 Access accepted only when CEN=0 and INIT_BUSY=0; otherwise no array or output change except hold.
REQ-017 Write (GWEN=0): each enabled lane k written with D lane k at A on the accepting edge; disabled lanes unchanged; Q and Q_VLD unaffected.
REQ-018 Write with all lanes disabled SHALL be a no-op and SHALL NOT be treated as a read.
REQ-019 Read (GWEN=1): latency 1 cycle when OUT_REG=0, 2 cycles when OUT_REG=1, measured from accepting edge to Q valid; Q_VLD=1 in exactly that cycle.
REQ-020 Back-to-back reads SHALL sustain one read per cycle at either OUT_REG setting.
REQ-021 Read of an address written in the previous cycle SHALL return the newly written data.
REQ-022 Q SHALL hold its last value in every cycle Q_VLD=0, including idle (CEN=1) and write cycles.
REQ-023 Address for the array SHALL be registered on accept; with CEN=1 the held address is presented, so array output is stable.
REQ-024 FSM states INIT, READY. INIT_EN=1: reset -> INIT; INIT_EN=0: reset -> READY.
REQ-025 INIT: internal counter starts at 0, writes all-zero, all lanes, one address per cycle; INIT_BUSY=1.
REQ-026 INIT -> READY on the edge writing address 2**ADDR_WIDTH-1 (counter wrap); INIT lasts exactly 2**ADDR_WIDTH cycles after reset release; INIT_BUSY=0 from the following cycle.
REQ-027 Requests during INIT are dropped, not queued; no Q_VLD is generated for them.
REQ-028 A read in flight in the OUT_REG pipeline when reset asserts SHALL be discarded (no Q_VLD after reset).

Reset
REQ-029 While cpurst_b=0 at an edge: Q=0, Q_VLD=0, pipeline valid bits=0, held address=0, init counter=0, state per REQ-024, INIT_BUSY=INIT_EN.
REQ-030 Reset asserted mid-INIT SHALL restart the sweep from address 0 after release.
REQ-031 Array contents are not reset by cpurst_b; with INIT_EN=0 contents are undefined until written.

Verification
REQ-032 Defaults, reset release -> INIT_BUSY=1 for 2048 cycles, then 0; read of any address (e.g. 0x5A3) -> Q=0x00000000, Q_VLD one cycle later.
REQ-033 Write A=0x010 D=0xAABBCCDD WEN=0xFFFF00FF (lane 1 only), prior contents 0x11223344 -> later read returns 0x1122CC44.
REQ-034 OUT_REG=1, reads of 0x001,0x002,0x003 on consecutive cycles -> Q_VLD high cycles 2,3,4 after first accept with matching data; Q held after.
REQ-035 Write 0x7FF=0xDEADBEEF then immediate read 0x7FF -> Q=0xDEADBEEF; idle 5 cycles -> Q unchanged, Q_VLD=0.
REQ-036 Reset pulse at INIT cycle 1000 -> sweep restarts, INIT_BUSY=1 for 2048 further cycles; read issued during INIT -> no Q_VLD.
REQ-037 Parameters ADDR_WIDTH=6, DATA_WIDTH=64, LANE_WIDTH=16, INIT_EN=0 -> INIT_BUSY=0 out of reset; per-lane write/read matches a reference model over 1000 random accesses.
